// File: rtl/disparity_cost_wta_if.sv
// Stream interface for the disparity cost / winner-take-all stage.
// The master side drives the synchronised left/right pixel stream and observes
// the delayed costs, winner and timing; the slave side is the datapath itself.
interface disparity_cost_wta_if #(
    parameter int PX_WIDTH = 8,
    parameter int MAX_DISP = 16,
    parameter int DISP_W   = 4
);
    logic                         de_in;
    logic                         h_sync_in;
    logic                         v_sync_in;
    logic [PX_WIDTH-1:0]          pixel_left;
    logic [PX_WIDTH-1:0]          pixel_right;

    logic                         de_out;
    logic                         h_sync_out;
    logic                         v_sync_out;
    logic [MAX_DISP*PX_WIDTH-1:0] cost_out;
    logic [DISP_W-1:0]            disp_out;
    logic [PX_WIDTH-1:0]          min_cost_out;

    modport master (
        output de_in, h_sync_in, v_sync_in, pixel_left, pixel_right,
        input  de_out, h_sync_out, v_sync_out, cost_out, disp_out, min_cost_out
    );

    modport slave (
        input  de_in, h_sync_in, v_sync_in, pixel_left, pixel_right,
        output de_out, h_sync_out, v_sync_out, cost_out, disp_out, min_cost_out
    );
endinterface

// File: rtl/disparity_cost_wta.sv
// Absolute-difference matching costs over MAX_DISP disparities followed by a
// pipelined winner-take-all comparator tree. Fixed latency of 2 + DISP_W
// cycles, one pixel per clock, no back-pressure.
module disparity_cost_wta #(
    parameter int PX_WIDTH  = 8,
    parameter int MAX_DISP  = 16,
    parameter int DISP_W    = 4,
    parameter int COL_WIDTH = 11
) (
    input  logic clk,
    input  logic rst,
    disparity_cost_wta_if.slave bus
);

    localparam int LAT    = 2 + DISP_W;
    localparam int NODES  = MAX_DISP - 1;
    localparam int CW     = MAX_DISP * PX_WIDTH;
    localparam logic [PX_WIDTH-1:0]  COST_MAX = '1;
    localparam logic [COL_WIDTH-1:0] COL_MAX  = '1;

    // |a - b| formed in PX_WIDTH+1 signed bits; the magnitude always fits
    // back into PX_WIDTH so the truncation loses nothing.
    function automatic logic [PX_WIDTH-1:0] abs_diff(input logic [PX_WIDTH-1:0] a,
                                                     input logic [PX_WIDTH-1:0] b);
        logic signed [PX_WIDTH:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return PX_WIDTH'((diff < 0) ? -diff : diff);
    endfunction

    logic [COL_WIDTH-1:0] col_cnt;
    logic                 de_prev;

    logic [PX_WIDTH-1:0]  left_p1;
    logic [PX_WIDTH-1:0]  hist_p1 [MAX_DISP];
    logic                 de_p1;
    logic                 h_sync_p1;
    logic                 v_sync_p1;
    logic [COL_WIDTH-1:0] col_p1;

    logic [PX_WIDTH-1:0]  cost_p2 [MAX_DISP];
    logic [CW-1:0]        cost_flat_p2;

    logic [LAT-2:0]       de_dly;
    logic [LAT-2:0]       h_sync_dly;
    logic [LAT-2:0]       v_sync_dly;

    logic [CW-1:0]        cost_dly  [DISP_W];
    logic [PX_WIDTH-1:0]  tree_cost [NODES];
    logic [DISP_W-1:0]    tree_idx  [NODES];
    logic [PX_WIDTH-1:0]  node_cost [2*MAX_DISP-1];
    logic [DISP_W-1:0]    node_idx  [2*MAX_DISP-1];

    // Column counter: position of the next active pixel within the line.
    // Cleared during vertical blanking and on the falling edge of de.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            de_prev <= 1'b0;
        end else begin
            de_prev <= bus.de_in;
            if (bus.v_sync_in) begin
                col_cnt <= '0;
            end else if (bus.de_in) begin
                if (col_cnt != COL_MAX) begin
                    col_cnt <= col_cnt + COL_WIDTH'(1);
                end
            end else if (de_prev) begin
                col_cnt <= '0;
            end
        end
    end

    // Stage 1: register the pixel, timing and column; shift the right-pixel
    // history only on active cycles so blanking does not disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_p1   <= '0;
            de_p1     <= 1'b0;
            h_sync_p1 <= 1'b0;
            v_sync_p1 <= 1'b1;
            col_p1    <= '0;
            for (int d = 0; d < MAX_DISP; d++) begin
                hist_p1[d] <= '0;
            end
        end else begin
            left_p1   <= bus.pixel_left;
            de_p1     <= bus.de_in;
            h_sync_p1 <= bus.h_sync_in;
            v_sync_p1 <= bus.v_sync_in;
            col_p1    <= col_cnt;
            if (bus.de_in) begin
                hist_p1[0] <= bus.pixel_right;
                for (int d = MAX_DISP - 1; d > 0; d--) begin
                    hist_p1[d] <= hist_p1[d-1];
                end
            end
        end
    end

    // Stage 2: per-disparity cost; disparities reaching left of the image
    // edge, and inactive cycles, get the maximum cost so they never win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < MAX_DISP; d++) begin
                cost_p2[d] <= COST_MAX;
            end
        end else begin
            for (int d = 0; d < MAX_DISP; d++) begin
                if (de_p1 && (col_p1 >= COL_WIDTH'(d))) begin
                    cost_p2[d] <= abs_diff(left_p1, hist_p1[d]);
                end else begin
                    cost_p2[d] <= COST_MAX;
                end
            end
        end
    end

    // Pack the stage-2 costs into the output slice layout.
    always_comb begin
        cost_flat_p2 = '0;
        for (int d = 0; d < MAX_DISP; d++) begin
            cost_flat_p2[d*PX_WIDTH +: PX_WIDTH] = cost_p2[d];
        end
    end

    // Timing signals ride a plain shift register from stage 1 to the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_dly     <= '0;
            h_sync_dly <= '0;
            v_sync_dly <= '1;
        end else begin
            de_dly[0]     <= de_p1;
            h_sync_dly[0] <= h_sync_p1;
            v_sync_dly[0] <= v_sync_p1;
            for (int i = LAT - 2; i > 0; i--) begin
                de_dly[i]     <= de_dly[i-1];
                h_sync_dly[i] <= h_sync_dly[i-1];
                v_sync_dly[i] <= v_sync_dly[i-1];
            end
        end
    end

    // Full cost vector is delayed one register per tree level so it lines up
    // with the winner at the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DISP_W; i++) begin
                cost_dly[i] <= '1;
            end
        end else begin
            cost_dly[0] <= cost_flat_p2;
            for (int i = DISP_W - 1; i > 0; i--) begin
                cost_dly[i] <= cost_dly[i-1];
            end
        end
    end

    // Heap view of the tree: nodes 0..NODES-1 are registered comparators,
    // nodes NODES.. are the stage-2 leaves. Children of node i are 2i+1 and
    // 2i+2, and the left child always covers the lower disparities.
    always_comb begin
        for (int i = 0; i < 2*MAX_DISP - 1; i++) begin
            node_cost[i] = COST_MAX;
            node_idx[i]  = '0;
        end
        for (int i = 0; i < NODES; i++) begin
            node_cost[i] = tree_cost[i];
            node_idx[i]  = tree_idx[i];
        end
        for (int d = 0; d < MAX_DISP; d++) begin
            node_cost[NODES+d] = cost_p2[d];
            node_idx[NODES+d]  = DISP_W'(d);
        end
    end

    // Stages 3..2+DISP_W: each comparator level is one register stage. The
    // right (higher-index) child wins only on a strictly smaller cost, which
    // makes ties resolve to the smallest disparity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NODES; i++) begin
                tree_cost[i] <= COST_MAX;
                tree_idx[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NODES; i++) begin
                if (node_cost[2*i+2] < node_cost[2*i+1]) begin
                    tree_cost[i] <= node_cost[2*i+2];
                    tree_idx[i]  <= node_idx[2*i+2];
                end else begin
                    tree_cost[i] <= node_cost[2*i+1];
                    tree_idx[i]  <= node_idx[2*i+1];
                end
            end
        end
    end

    assign bus.de_out       = de_dly[LAT-2];
    assign bus.h_sync_out   = h_sync_dly[LAT-2];
    assign bus.v_sync_out   = v_sync_dly[LAT-2];
    assign bus.cost_out     = cost_dly[DISP_W-1];
    assign bus.disp_out     = tree_idx[0];
    assign bus.min_cost_out = tree_cost[0];

endmodule

// File: tb/tb_disparity_cost_wta.sv
// Randomised and directed stimulus for disparity_cost_wta, checked every cycle
// against a line/queue level reference model of the matching-cost rules.
module tb_disparity_cost_wta;

    localparam int PX_WIDTH = 8;
    localparam int MAX_DISP = 16;
    localparam int DISP_W   = 4;
    localparam int LAT      = 2 + DISP_W;
    localparam int CW       = MAX_DISP * PX_WIDTH;
    localparam int DEPTH    = 8192;
    localparam int COL_SAT  = 2047;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   rst_level = 1'b1;

    disparity_cost_wta_if #(.PX_WIDTH(PX_WIDTH), .MAX_DISP(MAX_DISP), .DISP_W(DISP_W)) bus();

    disparity_cost_wta #(
        .PX_WIDTH(PX_WIDTH), .MAX_DISP(MAX_DISP), .DISP_W(DISP_W), .COL_WIDTH(11)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic                exp_de   [DEPTH];
    logic                exp_h    [DEPTH];
    logic                exp_v    [DEPTH];
    logic [CW-1:0]       exp_cost [DEPTH];
    logic [DISP_W-1:0]   exp_disp [DEPTH];
    logic [PX_WIDTH-1:0] exp_min  [DEPTH];
    int                  shift_x  [DEPTH];
    bit                  tie_px   [DEPTH];

    int                  col_model;
    bit                  prev_de;
    logic [PX_WIDTH-1:0] hist [$];

    task automatic check_val(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic set_reset_entry(input int n);
        if (n >= 0 && n < DEPTH) begin
            exp_de[n]   = 1'b0;
            exp_h[n]    = 1'b0;
            exp_v[n]    = 1'b1;
            exp_cost[n] = '1;
            exp_disp[n] = '0;
            exp_min[n]  = '1;
            shift_x[n]  = -1;
            tie_px[n]   = 1'b0;
        end
    endtask

    task automatic model_reset();
        col_model = 0;
        prev_de   = 1'b0;
        hist      = {};
        for (int d = 0; d < MAX_DISP; d++) hist.push_back('0);
    endtask

    // Reference: column = number of active pixels since the line began,
    // cost[d] = |L - right pixel d active pixels ago| when that pixel lies on
    // the current line, winner = first minimum scanning upward in d.
    task automatic model_push(input bit de, input bit h, input bit v,
                              input logic [PX_WIDTH-1:0] l, input logic [PX_WIDTH-1:0] r);
        int pc;
        int best;
        int cd [MAX_DISP];
        logic [CW-1:0] packed_cost;
        pc = col_model;
        if (v) col_model = 0;
        else if (de) begin
            if (col_model < COL_SAT) col_model++;
        end else if (prev_de) col_model = 0;
        prev_de = de;
        if (de) begin
            hist.push_front(r);
            if (hist.size() > MAX_DISP) hist.delete(MAX_DISP);
        end
        packed_cost = '0;
        for (int d = 0; d < MAX_DISP; d++) begin
            int a;
            int b;
            a = int'(l);
            b = int'(hist[d]);
            if (de && d <= pc) cd[d] = (a > b) ? a - b : b - a;
            else cd[d] = 255;
            packed_cost[d*PX_WIDTH +: PX_WIDTH] = PX_WIDTH'(cd[d]);
        end
        best = 0;
        for (int d = 1; d < MAX_DISP; d++) if (cd[d] < cd[best]) best = d;
        exp_de[cyc]   = de;
        exp_h[cyc]    = h;
        exp_v[cyc]    = v;
        exp_cost[cyc] = packed_cost;
        exp_disp[cyc] = DISP_W'(best);
        exp_min[cyc]  = PX_WIDTH'(cd[best]);
    endtask

    task automatic check_outputs();
        int n;
        logic [CW-1:0] cv;
        n = cyc - LAT;
        if (n < 0) begin
            check_val("de_out", CW'(bus.de_out), CW'(1'b0));
            check_val("v_sync_out", CW'(bus.v_sync_out), CW'(1'b1));
            check_val("disp_out", CW'(bus.disp_out), CW'(0));
            check_val("min_cost_out", CW'(bus.min_cost_out), CW'(8'hFF));
            check_val("cost_out", bus.cost_out, {CW{1'b1}});
        end else begin
            check_val("de_out", CW'(bus.de_out), CW'(exp_de[n]));
            check_val("h_sync_out", CW'(bus.h_sync_out), CW'(exp_h[n]));
            check_val("v_sync_out", CW'(bus.v_sync_out), CW'(exp_v[n]));
            check_val("disp_out", CW'(bus.disp_out), CW'(exp_disp[n]));
            check_val("min_cost_out", CW'(bus.min_cost_out), CW'(exp_min[n]));
            check_val("cost_out", bus.cost_out, exp_cost[n]);
            if (shift_x[n] >= 5) begin
                check_val("shift_disp", CW'(bus.disp_out), CW'(5));
                check_val("shift_min", CW'(bus.min_cost_out), CW'(0));
            end else if (shift_x[n] >= 0) begin
                cv = bus.cost_out;
                for (int d = shift_x[n] + 1; d < MAX_DISP; d++)
                    check_val("shift_edge_mask", CW'(cv[d*PX_WIDTH +: PX_WIDTH]), CW'(8'hFF));
            end
            if (tie_px[n]) begin
                check_val("tie_disp", CW'(bus.disp_out), CW'(0));
                check_val("tie_min", CW'(bus.min_cost_out), CW'(0));
            end
        end
    endtask

    task automatic step(input bit de, input bit h, input bit v,
                        input logic [PX_WIDTH-1:0] l, input logic [PX_WIDTH-1:0] r,
                        input int sx, input bit tie);
        @(posedge clk);
        #1;
        check_outputs();
        rst             = rst_level;
        bus.de_in       = de;
        bus.h_sync_in   = h;
        bus.v_sync_in   = v;
        bus.pixel_left  = l;
        bus.pixel_right = r;
        if (rst_level) set_reset_entry(cyc);
        else begin
            model_push(de, h, v, l, r);
            shift_x[cyc] = sx;
            tie_px[cyc]  = tie;
        end
        cyc++;
    endtask

    task automatic px(input logic [PX_WIDTH-1:0] l, input logic [PX_WIDTH-1:0] r);
        step(1'b1, 1'b0, 1'b0, l, r, -1, 1'b0);
    endtask

    task automatic idle(input bit h, input bit v);
        step(1'b0, h, v, PX_WIDTH'($urandom), PX_WIDTH'($urandom), -1, 1'b0);
    endtask

    task automatic rand_line(input int len);
        for (int x = 0; x < len; x++) px(PX_WIDTH'($urandom), PX_WIDTH'($urandom));
    endtask

    task automatic line_gap(input int len, input bit v);
        for (int i = 0; i < len; i++) idle(i == 0, v);
    endtask

    // Reset asserted between clock edges; outputs must drop immediately and
    // everything in flight is discarded.
    task automatic async_reset();
        @(posedge clk);
        #1;
        check_outputs();
        #2;
        rst       = 1'b1;
        rst_level = 1'b1;
        #1;
        check_val("async_de_out", CW'(bus.de_out), CW'(1'b0));
        check_val("async_h_sync_out", CW'(bus.h_sync_out), CW'(1'b0));
        check_val("async_v_sync_out", CW'(bus.v_sync_out), CW'(1'b1));
        check_val("async_disp_out", CW'(bus.disp_out), CW'(0));
        check_val("async_min_cost", CW'(bus.min_cost_out), CW'(8'hFF));
        check_val("async_cost_out", bus.cost_out, {CW{1'b1}});
        for (int k = cyc - LAT + 1; k <= cyc; k++) set_reset_entry(k);
        model_reset();
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) set_reset_entry(i);
        model_reset();
        bus.de_in       = 1'b0;
        bus.h_sync_in   = 1'b0;
        bus.v_sync_in   = 1'b1;
        bus.pixel_left  = '0;
        bus.pixel_right = '0;

        // Held in reset with random activity on the inputs.
        rst_level = 1'b1;
        for (int i = 0; i < 8; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 PX_WIDTH'($urandom), PX_WIDTH'($urandom), -1, 1'b0);
        rst_level = 1'b0;
        for (int i = 0; i < 4; i++) idle(1'b0, 1'b1);

        // Single de pulse with sync toggles at known cycles.
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        px(8'h12, 8'h34);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) idle(1'b0, 1'b1);

        // Known shift of 5 pixels across a 64-pixel line.
        for (int x = 0; x < 64; x++)
            step(1'b1, 1'b0, 1'b0,
                 (x >= 5) ? PX_WIDTH'((x - 5) * 3) : PX_WIDTH'($urandom),
                 PX_WIDTH'(x * 3), x, 1'b0);
        line_gap(3, 1'b0);

        // Flat line: every valid cost is zero, lowest disparity must win.
        for (int x = 0; x < 32; x++) step(1'b1, 1'b0, 1'b0, 8'h40, 8'h40, -1, 1'b1);
        line_gap(4, 1'b0);

        // Two lines back to back; history of the first must not leak.
        rand_line(20);
        line_gap(3, 1'b0);
        rand_line(20);
        line_gap(2, 1'b0);

        // Extreme pixel values and a known mid-range difference.
        px(8'h00, 8'hFF);
        px(8'hFF, 8'h00);
        px(8'h00, 8'hFF);
        line_gap(2, 1'b0);
        px(8'hFF, 8'h00);
        px(8'h00, 8'hFF);
        line_gap(2, 1'b0);
        for (int x = 0; x < 20; x++) px(8'h10, 8'h30);
        line_gap(2, 1'b0);

        // Frame boundary: vertical blanking restarts the column count.
        rand_line(18);
        line_gap(5, 1'b1);
        rand_line(18);
        line_gap(2, 1'b0);

        // Vertical sync raised in the middle of a line.
        rand_line(10);
        step(1'b1, 1'b0, 1'b1, PX_WIDTH'($urandom), PX_WIDTH'($urandom), -1, 1'b0);
        rand_line(12);
        line_gap(3, 1'b0);

        // Random frames with random line lengths and gaps.
        for (int ln = 0; ln < 40; ln++) begin
            rand_line(int'($urandom_range(1, 40)));
            line_gap(int'($urandom_range(1, 5)), ($urandom_range(0, 7) == 0));
        end

        // Reset in the middle of a line, then resume.
        rand_line(10);
        async_reset();
        for (int i = 0; i < 3; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 PX_WIDTH'($urandom), PX_WIDTH'($urandom), -1, 1'b0);
        rst_level = 1'b0;
        idle(1'b0, 1'b0);
        rand_line(25);
        line_gap(3, 1'b0);

        // Long line past column-counter saturation.
        rand_line(2100);
        line_gap(3, 1'b1);

        for (int i = 0; i < LAT + 2; i++) idle(1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/disparity_cost_wta.md
Name: disparity_cost_wta

Overview:
- Stage directly downstream of the half-image splitter in the SGM pipeline.
- Consumes the synchronised left/right grey pixel streams with their de/h_sync/v_sync.
- For every active pixel, computes absolute-difference matching costs over disparities 0..MAX_DISP-1.
- Selects the winner-take-all disparity and emits costs, winner, and timing signals delayed by a fixed latency.

Parameters:
- PX_WIDTH, 8, pixel and cost width in bits.
- MAX_DISP, 16, number of disparities; power of two, >= 2.
- DISP_W, 4, width of the disparity index; equals log2(MAX_DISP).
- COL_WIDTH, 11, width of the internal column counter.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- de_in  in  1  data enable; 1 = active pixel.
- h_sync_in  in  1  horizontal sync, passed through with delay.
- v_sync_in  in  1  vertical sync; 1 = no image (blanking).
- pixel_left  in  PX_WIDTH  left image pixel, column x.
- pixel_right  in  PX_WIDTH  right image pixel, column x.
- de_out  out  1  de_in delayed by LAT.
- h_sync_out  out  1  h_sync_in delayed by LAT.
- v_sync_out  out  1  v_sync_in delayed by LAT.
- cost_out  out  MAX_DISP*PX_WIDTH  packed costs; slice d = bits [d*PX_WIDTH +: PX_WIDTH].
- disp_out  out  DISP_W  winning disparity.
- min_cost_out  out  PX_WIDTH  cost of the winning disparity.

Behaviour:
- Reset (asynchronous, active-high):
  - all pipeline registers clear.
  - de_out=0, h_sync_out=0, v_sync_out=1, cost_out=all ones, disp_out=0, min_cost_out=all ones.
  - column counter=0, right-pixel history=0.
- Latency: LAT = 2 + DISP_W cycles (default 6), fixed. No back-pressure; one pixel accepted per clock.
- Column counter:
  - Cleared while v_sync_in=1, and on the first cycle with de_in=0 after de_in=1 (end of line).
  - Increments on each de_in=1 cycle; saturates at 2^COL_WIDTH-1.
- Stage 1 (register):
  - Register pixel_left, de, syncs, and col.
  - When de_in=1, shift pixel_right into history: R[0]=newest, R[d]=right pixel d active cycles earlier.
  - When de_in=0, the history holds its contents.
- Stage 2 (cost): for each d, cost[d] = |L - R[d]|, computed at PX_WIDTH+1 bits then truncated; result always fits PX_WIDTH.
  - Forced to all ones (COST_MAX) when col < d, because the pixel lies outside the image in the right view.
  - All costs forced to COST_MAX when the registered de = 0.
- Stages 3..2+DISP_W (WTA): balanced binary comparator tree, one level per register stage.
  - Each node carries a (cost, index) pair.
  - The strictly smaller cost wins; on a tie, the smaller index wins.
  - cost_out is delayed alongside the tree so all outputs are cycle-aligned.
- de=0 output cycles: cost_out all COST_MAX, disp_out=0, min_cost_out=COST_MAX.
- v_sync_in=1 mid-line: the counter clears immediately; pixels already in flight complete normally.
- Reset mid-frame: outputs return to reset values asynchronously. After release, the first valid output appears LAT cycles after the first de_in=1.
- Column 0 of every line: only d=0 is valid, so disp_out=0 and min_cost_out=|L-R|.

Test Plan:
- Reset check:
  - Hold rst=1 with random inputs -> de_out=0, v_sync_out=1, disp_out=0, min_cost_out=0xFF, cost_out all 0xFF.
  - Release rst -> values hold until valid data has propagated.
- Latency:
  - Single de pulse, with h_sync/v_sync toggled at known cycles -> de_out, h_sync_out, v_sync_out reproduce the pattern exactly 6 cycles later.
- Known shift:
  - 64-px line, right[x]=x*3, left[x]=right[x-5] for x>=5 -> disp_out=5, min_cost_out=0 for x>=5.
  - Column x<5 -> disp_out=x or the lowest-cost valid d; cost slices with d>x equal 0xFF.
- Tie-break:
  - Constant left=right=0x40 across the line -> all valid costs 0; disp_out=0 on every pixel.
- Line and frame boundaries:
  - Two lines separated by de=0 gap -> the second line's column-0 costs show 0xFF for d>=1; no history from line 1 is used.
  - v_sync_in=1 between frames -> counter restarts at 0.
- Saturation and absolute difference:
  - left=0x00, right=0xFF -> cost 0xFF.
  - left=0xFF, right=0x00 -> cost 0xFF.
  - left=0x10, right=0x30 -> cost 0x20 for the matching d.
